handshake_fifo_break_dv: RTL and testbench
==========================================

Name: handshake_fifo_break_dv

Overview:
- Elastic FIFO buffer for the dataflow handshake fabric. It sits directly downstream of constant-generator and other operator stages.
- It accepts `ins`/`ins_valid` tokens, for example a constant value triggered by a control token. It stores up to NUM_SLOTS tokens and presents them in order on `outs`.
- Both `outs_valid` and `ins_ready` are driven from registers. This breaks the combinational valid and ready paths that constant and fork stages otherwise chain through.

Parameters:
- DATA_WIDTH, 32: width of `ins`/`outs` data in bits.
- NUM_SLOTS, 4: FIFO capacity in tokens. Legal values are 2 to 64. Powers of two are not required.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset; asynchronous, active-low; state cleared while rst=0.
- ins  input  DATA_WIDTH  token data from the upstream stage.
- ins_valid  input  1  upstream token present.
- ins_ready  output  1  buffer can accept a token this cycle.
- outs  output  DATA_WIDTH  head-of-queue token data.
- outs_valid  output  1  head token present.
- outs_ready  input  1  downstream accepts the head token.

Behaviour:
- State:
  - Storage array mem[0..NUM_SLOTS-1].
  - Head pointer rd_ptr and tail pointer wr_ptr, each clog2(NUM_SLOTS) bits (minimum 1).
  - Occupancy counter count, clog2(NUM_SLOTS+1) bits.
  - Registered flags empty_r and full_r.
- Reset (rst=0, asynchronous):
  - rd_ptr=0, wr_ptr=0, count=0, empty_r=1, full_r=0, all mem entries=0.
  - Therefore outs=0, outs_valid=0, ins_ready=1.
  - Handshakes presented while rst=0 are ignored; no state change.
- Output equations:
  - outs_valid = !empty_r.
  - ins_ready = !full_r.
  - outs = mem[rd_ptr].
  - No combinational path from any input to any output.
- Push = ins_valid && ins_ready. On push: mem[wr_ptr] <= ins, and wr_ptr advances.
- Pop = outs_valid && outs_ready. On pop: rd_ptr advances.
- Pointer wrap: a pointer equal to NUM_SLOTS-1 advances to 0. This must be correct for non-power-of-two NUM_SLOTS; e.g. NUM_SLOTS=3 gives the sequence 0,1,2,0.
- Counter update:
  - Push only: count+1.
  - Pop only: count-1.
  - Both or neither: count unchanged.
  - Flags are computed from the next count: empty_r <= (count_next==0), full_r <= (count_next==NUM_SLOTS).
- Latency:
  - A token pushed at edge N is visible at `outs` with outs_valid=1 after edge N.
  - Minimum input-to-output latency is 1 cycle. There is no bypass when empty.
- Throughput: 1 token per cycle sustained when neither full nor empty.
- Empty boundary:
  - No pop is possible.
  - A push makes outs_valid=1 the next cycle and leaves outs holding the pushed value.
- Full boundary:
  - ins_ready=0, so no push is possible even if outs_ready=1 in the same cycle. This is deliberate: ready is registered.
  - A pop deasserts full_r, and ins_ready=1 from the next cycle.
- Simultaneous push and pop at 0<count<NUM_SLOTS: the data order is preserved.
- Stall: with outs_ready=0 and outs_valid=1, `outs` and outs_valid hold stable until the pop.
- Reset mid-operation: all stored tokens are discarded, and the outputs take their reset values immediately, asynchronously.
- Order: strict FIFO. No token is duplicated or dropped.

Test Plan:
- Reset then idle:
  - rst=0 for 3 cycles, then release.
  - Required: outs_valid=0, ins_ready=1, outs=0 throughout, and no change in any output for 5 idle cycles.
- Single token:
  - Push ins=5 (decimal), then hold outs_ready=1.
  - Required: outs_valid=1 and outs=5 exactly one cycle after the push edge, then outs_valid=0 after the pop edge.
- Fill and backpressure:
  - NUM_SLOTS=4, outs_ready=0, push 1,2,3,4,5 on consecutive cycles.
  - Required: ins_ready=0 after the 4th push; the 5th token is not accepted.
  - Then outs_ready=1 yields 1,2,3,4. Token 5 is accepted only in the cycle after the first pop.
- Streaming:
  - ins_valid=1 and outs_ready=1 continuously with ins=0..19.
  - Required: outs delivers 0..19 in order, one per cycle, after 1 cycle of latency; count never exceeds 1.
- Wrap with non-power-of-two depth:
  - NUM_SLOTS=3, 10 random push/pop mixes including full and empty simultaneous push+pop.
  - Required: output sequence matches a reference queue model, and ins_ready/outs_valid match count==3 / count==0 of the model.
- Reset mid-operation:
  - With 3 tokens stored, pulse rst=0 for 1 cycle mid-period.
  - Required: outs_valid drops to 0 and outs to 0 asynchronously, and after release the first pushed token (e.g. 7) is the first one out.

Source files
------------

// File: rtl/handshake_fifo_break_dv_if.sv
// Token handshake bundle between an upstream operator stage, the elastic FIFO
// and its downstream consumer.
interface handshake_fifo_break_dv_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] ins;
  logic                  ins_valid;
  logic                  ins_ready;
  logic [DATA_WIDTH-1:0] outs;
  logic                  outs_valid;
  logic                  outs_ready;

  modport master (
    output ins, ins_valid, outs_ready,
    input  ins_ready, outs, outs_valid
  );

  modport slave (
    input  ins, ins_valid, outs_ready,
    output ins_ready, outs, outs_valid
  );
endinterface

// File: rtl/handshake_fifo_break_dv.sv
// Elastic FIFO whose valid and ready outputs both come straight from registers,
// cutting the combinational handshake chain between dataflow stages.
module handshake_fifo_break_dv #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLOTS  = 4
) (
  input logic                    clk,
  input logic                    rst,
  handshake_fifo_break_dv_if.slave bus
);
  localparam int PTR_W = (NUM_SLOTS > 2) ? $clog2(NUM_SLOTS) : 1;
  localparam int CNT_W = $clog2(NUM_SLOTS + 1);

  logic [DATA_WIDTH-1:0] r_mem [NUM_SLOTS];
  logic [PTR_W-1:0]      r_rdPtr;
  logic [PTR_W-1:0]      r_wrPtr;
  logic [CNT_W-1:0]      r_count;
  logic [CNT_W-1:0]      w_countNext;
  logic                  r_empty;
  logic                  r_full;
  logic                  w_push;
  logic                  w_pop;

  // Explicit wrap keeps non-power-of-two depths from walking past the last slot.
  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(NUM_SLOTS - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign w_push = bus.ins_valid && !r_full;
  assign w_pop  = !r_empty && bus.outs_ready;

  assign bus.ins_ready  = !r_full;
  assign bus.outs_valid = !r_empty;
  assign bus.outs       = r_mem[r_rdPtr];

  always_comb begin
    w_countNext = r_count;
    if (w_push && !w_pop) begin
      w_countNext = r_count + 1'b1;
    end else if (w_pop && !w_push) begin
      w_countNext = r_count - 1'b1;
    end
  end

  // Flags are derived from the next occupancy so they stay registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_mem[i] <= '0;
      end
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wrPtr] <= bus.ins;
        r_wrPtr        <= nextPtr(r_wrPtr);
      end
      if (w_pop) begin
        r_rdPtr <= nextPtr(r_rdPtr);
      end
      r_count <= w_countNext;
      r_empty <= (w_countNext == '0);
      r_full  <= (w_countNext == CNT_W'(NUM_SLOTS));
    end
  end
endmodule

// File: tb/tb_handshake_fifo_break_dv.sv
// Drives a 4-deep and a 3-deep FIFO with identical traffic and checks both
// against queue-based reference models through a scoreboard.
module tb_handshake_fifo_break_dv;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        insValid = 1'b0;
  logic [31:0] insData = '0;
  logic        outsReady = 1'b0;

  int checks = 0;
  int fails  = 0;

  logic [31:0] expq4[$];
  logic [31:0] expq3[$];
  int          cnt4 = 0;
  int          cnt3 = 0;
  int          pushes4 = 0;
  int          pushes3 = 0;

  handshake_fifo_break_dv_if #(.DATA_WIDTH(32)) bus4 ();
  handshake_fifo_break_dv_if #(.DATA_WIDTH(32)) bus3 ();

  assign bus4.ins        = insData;
  assign bus4.ins_valid  = insValid;
  assign bus4.outs_ready = outsReady;
  assign bus3.ins        = insData;
  assign bus3.ins_valid  = insValid;
  assign bus3.outs_ready = outsReady;

  handshake_fifo_break_dv #(.DATA_WIDTH(32), .NUM_SLOTS(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  handshake_fifo_break_dv #(.DATA_WIDTH(32), .NUM_SLOTS(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [31:0] d, input logic ordy);
    insValid  = iv;
    insData   = d;
    outsReady = ordy;
    @(posedge clk);
    #1;
  endtask

  // Reference models: tokens enter when the modelled occupancy is below depth.
  always @(posedge clk) begin
    if (rst) begin
      automatic bit push4 = insValid && (cnt4 < 4);
      automatic bit pop4  = outsReady && (cnt4 > 0);
      automatic bit push3 = insValid && (cnt3 < 3);
      automatic bit pop3  = outsReady && (cnt3 > 0);
      cnt4 = cnt4 + int'(push4) - int'(pop4);
      cnt3 = cnt3 + int'(push3) - int'(pop3);
      if (push4) begin
        expq4.push_back(insData);
        pushes4++;
      end
      if (push3) begin
        expq3.push_back(insData);
        pushes3++;
      end
    end
  end

  always @(negedge rst) begin
    expq4.delete();
    expq3.delete();
    cnt4 = 0;
    cnt3 = 0;
    pushes4 = 0;
    pushes3 = 0;
  end

  // Monitor: compares flags and head data mid-cycle, retiring heads that will pop.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("rst_valid4", 32'(bus4.outs_valid), 32'd0);
      checkOutput("rst_ready4", 32'(bus4.ins_ready), 32'd1);
      checkOutput("rst_outs4", bus4.outs, 32'd0);
      checkOutput("rst_valid3", 32'(bus3.outs_valid), 32'd0);
      checkOutput("rst_ready3", 32'(bus3.ins_ready), 32'd1);
      checkOutput("rst_outs3", bus3.outs, 32'd0);
    end else begin
      checkOutput("valid4", 32'(bus4.outs_valid), 32'(cnt4 != 0));
      checkOutput("ready4", 32'(bus4.ins_ready), 32'(cnt4 != 4));
      checkOutput("valid3", 32'(bus3.outs_valid), 32'(cnt3 != 0));
      checkOutput("ready3", 32'(bus3.ins_ready), 32'(cnt3 != 3));
      if (pushes4 == 0) checkOutput("idle_outs4", bus4.outs, 32'd0);
      if (pushes3 == 0) checkOutput("idle_outs3", bus3.outs, 32'd0);
      if (cnt4 != 0) begin
        if (expq4.size() == 0) checkOutput("underflow4", 32'd1, 32'd0);
        else begin
          checkOutput("data4", bus4.outs, expq4[0]);
          if (outsReady) void'(expq4.pop_front());
        end
      end
      if (cnt3 != 0) begin
        if (expq3.size() == 0) checkOutput("underflow3", 32'd1, 32'd0);
        else begin
          checkOutput("data3", bus3.outs, expq3[0]);
          if (outsReady) void'(expq3.pop_front());
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (5) applyStimulus(1'b0, 32'd0, 1'b0);

    applyStimulus(1'b1, 32'd5, 1'b1);
    repeat (3) applyStimulus(1'b0, 32'd0, 1'b1);

    for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 32'(i), 1'b0);
    checkOutput("full_ready4", 32'(bus4.ins_ready), 32'd0);
    repeat (3) applyStimulus(1'b1, 32'd5, 1'b1);
    repeat (6) applyStimulus(1'b0, 32'd0, 1'b1);

    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 32'(i), 1'b1);
    repeat (3) applyStimulus(1'b0, 32'd0, 1'b1);

    for (int phase = 0; phase < 6; phase++) begin
      for (int c = 0; c < 40; c++) begin
        automatic int pv = (phase % 3 == 0) ? 85 : (phase % 3 == 1) ? 25 : 60;
        automatic int pr = (phase % 3 == 0) ? 25 : (phase % 3 == 1) ? 85 : 60;
        applyStimulus(32'($urandom_range(0, 99)) < 32'(pv), $urandom,
                      32'($urandom_range(0, 99)) < 32'(pr));
      end
    end
    repeat (6) applyStimulus(1'b0, 32'd0, 1'b1);

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'(100 + i), 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_valid4", 32'(bus4.outs_valid), 32'd0);
    checkOutput("async_outs4", bus4.outs, 32'd0);
    checkOutput("async_valid3", 32'(bus3.outs_valid), 32'd0);
    checkOutput("async_outs3", bus3.outs, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    applyStimulus(1'b1, 32'd7, 1'b0);
    applyStimulus(1'b1, 32'd8, 1'b0);
    checkOutput("first_after_rst4", bus4.outs, 32'd7);
    checkOutput("first_after_rst3", bus3.outs, 32'd7);
    repeat (4) applyStimulus(1'b0, 32'd0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
